// File: rtl/io_read_port_ctrl_if.sv
// Producer handshake and processor read path of io_read_port_ctrl.
// master = producers + processor side, slave = the port controller.
interface io_read_port_ctrl_if #(
    parameter int WORD_WIDTH = 36,
    parameter int ADDR_WIDTH = 10,
    parameter int PORT_COUNT = 4
);
    // Producer handshake: a word on in_data[p] transfers on a rising edge
    // where in_valid[p] && in_ready[p]; valid may rise independently of ready,
    // and a producer holds valid and data stable until the transfer happens.
    logic [PORT_COUNT*WORD_WIDTH-1:0] in_data;
    logic [PORT_COUNT-1:0]            in_valid;
    logic [PORT_COUNT-1:0]            in_ready;

    logic [ADDR_WIDTH-1:0]            rd_addr;
    logic                             rd_en;
    logic [WORD_WIDTH-1:0]            rd_data;
    logic                             rd_data_valid;

    modport master (
        output in_data, in_valid, rd_addr, rd_en,
        input  in_ready, rd_data, rd_data_valid
    );

    modport slave (
        input  in_data, in_valid, rd_addr, rd_en,
        output in_ready, rd_data, rd_data_valid
    );
endinterface

// File: rtl/io_read_port_ctrl.sv
// Memory-mapped read ports: one-word holding slot per port with EMPTY/FULL state.
// Optional macro IO_READ_BYPASS_EN lets a FULL port accept a new word in the cycle it is read.
module io_read_port_ctrl #(
    parameter int WORD_WIDTH      = 36,
    parameter int ADDR_WIDTH      = 10,
    parameter int PORT_COUNT      = 4,
    parameter int PORT_BASE_ADDR  = 0,
    parameter int PORT_ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    io_read_port_ctrl_if.slave    bus,
    output logic [PORT_COUNT-1:0] port_EF,
    output logic [7:0]            underrun_count
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} port_state_t;

    localparam logic [31:0] BASE32  = 32'(PORT_BASE_ADDR);
    localparam logic [31:0] COUNT32 = 32'(PORT_COUNT);

    port_state_t           state [PORT_COUNT];
    logic [WORD_WIDTH-1:0] hold  [PORT_COUNT];

    logic [31:0]                addr_ext;
    logic [31:0]                addr_off;
    logic                       in_range;
    logic [PORT_ADDR_WIDTH-1:0] port_sel;
    logic [PORT_COUNT-1:0]      hit;
    logic [PORT_COUNT-1:0]      ready;
    logic [PORT_COUNT-1:0]      accept;
    logic                       read_ok;
    logic                       read_empty;
    logic [WORD_WIDTH-1:0]      read_word;

    // Unsigned wrap makes addresses below the base land far outside the range.
    assign addr_ext = 32'(bus.rd_addr);
    assign addr_off = addr_ext - BASE32;
    assign in_range = addr_off < COUNT32;
    assign port_sel = PORT_ADDR_WIDTH'(addr_off);

    always_comb begin
        hit       = '0;
        ready     = '0;
        port_EF   = '0;
        read_word = '0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            port_EF[p] = (state[p] == FULL);
            hit[p]     = bus.rd_en && in_range && (port_sel == PORT_ADDR_WIDTH'(p));
`ifdef IO_READ_BYPASS_EN
            ready[p]   = reset_n && ((state[p] == EMPTY) || hit[p]);
`else
            ready[p]   = reset_n && (state[p] == EMPTY);
`endif
            if (hit[p]) begin
                read_word = hold[p];
            end
        end
    end

    assign accept       = bus.in_valid & ready;
    assign bus.in_ready = ready;
    assign read_ok      = |(hit & port_EF);
    assign read_empty   = |(hit & ~port_EF);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                state[p] <= EMPTY;
                hold[p]  <= '0;
            end
            bus.rd_data       <= '0;
            bus.rd_data_valid <= 1'b0;
            underrun_count    <= '0;
        end else begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                case (state[p])
                    EMPTY: begin
                        if (accept[p]) begin
                            state[p] <= FULL;
                            hold[p]  <= bus.in_data[p*WORD_WIDTH +: WORD_WIDTH];
                        end
                    end
                    FULL: begin
                        // A read frees the slot unless a bypass refill lands in the same edge.
                        if (hit[p]) begin
                            if (accept[p]) begin
                                hold[p] <= bus.in_data[p*WORD_WIDTH +: WORD_WIDTH];
                            end else begin
                                state[p] <= EMPTY;
                            end
                        end
                    end
                    default: state[p] <= EMPTY;
                endcase
            end

            bus.rd_data_valid <= read_ok;
            if (read_ok) begin
                bus.rd_data <= read_word;
            end
            if (read_empty && (underrun_count != 8'hFF)) begin
                underrun_count <= underrun_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_io_read_port_ctrl.sv
// Bench for io_read_port_ctrl: directed scenarios plus random traffic,
// checked every cycle against a slot-level behavioural model.
module tb_io_read_port_ctrl;
    localparam int W    = 36;
    localparam int A    = 10;
    localparam int N    = 4;
    localparam int BASE = 32'h3F0;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] port_EF;
    logic [7:0]   underrun_count;

    io_read_port_ctrl_if #(.WORD_WIDTH(W), .ADDR_WIDTH(A), .PORT_COUNT(N)) bus ();

    io_read_port_ctrl #(
        .WORD_WIDTH(W), .ADDR_WIDTH(A), .PORT_COUNT(N),
        .PORT_BASE_ADDR(BASE), .PORT_ADDR_WIDTH(2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus            (bus),
        .port_EF        (port_EF),
        .underrun_count (underrun_count)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- model + scoreboard ----------------
    logic         m_full [N];
    logic [W-1:0] m_word [N];
    logic [W-1:0] m_rd_data;
    logic         m_rd_valid;
    int           m_under;
    logic [W-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hit_port();
        int a = int'(bus.rd_addr);
        if (bus.rd_en && a >= BASE && a < BASE + N) return a - BASE;
        return -1;
    endfunction

    function automatic logic m_ready(int p);
        if (!reset_n) return 1'b0;
        if (!m_full[p]) return 1'b1;
`ifdef IO_READ_BYPASS_EN
        return hit_port() == p;
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_reset();
        for (int p = 0; p < N; p++) begin
            m_full[p] = 1'b0;
            m_word[p] = '0;
        end
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_under    = 0;
        exp_q.delete();
    endtask

    initial m_reset();

    always @(posedge clock or negedge reset_n) begin
        int           hp;
        logic [N-1:0] acc;
        if (!reset_n) begin
            m_reset();
        end else begin
            hp = hit_port();
            for (int p = 0; p < N; p++) acc[p] = bus.in_valid[p] && m_ready(p);
            m_rd_valid = 1'b0;
            if (hp >= 0) begin
                if (m_full[hp]) begin
                    m_rd_data  = m_word[hp];
                    m_rd_valid = 1'b1;
                    exp_q.push_back(m_word[hp]);
                    m_full[hp] = 1'b0;
                end else if (m_under < 255) begin
                    m_under++;
                end
            end
            for (int p = 0; p < N; p++) begin
                if (acc[p]) begin
                    m_full[p] = 1'b1;
                    m_word[p] = bus.in_data[p*W +: W];
                end
            end
        end
    end

    always @(posedge clock) begin
        logic [N-1:0] exp_ef;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] front;
        #1;
        for (int p = 0; p < N; p++) begin
            exp_ef[p]  = m_full[p];
            exp_rdy[p] = m_ready(p);
        end
        check("port_EF", port_EF, exp_ef);
        check("in_ready", bus.in_ready, exp_rdy);
        check("rd_data_valid", bus.rd_data_valid, m_rd_valid);
        check("rd_data", bus.rd_data, m_rd_data);
        check("underrun_count", underrun_count, m_under[7:0]);
        if (bus.rd_data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("read_queue_nonempty", 0, 1);
            end else begin
                front = exp_q.pop_front();
                check("read_queue_word", bus.rd_data, front);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic idle();
        bus.in_valid = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic random_phase(input int cycles);
        logic [63:0] r;
        repeat (cycles) begin
            @(negedge clock);
            bus.in_valid = N'($urandom_range(0, 15));
            for (int p = 0; p < N; p++) begin
                r = {$urandom(), $urandom()};
                bus.in_data[p*W +: W] = r[W-1:0];
            end
            bus.rd_en   = ($urandom_range(0, 3) != 0);
            bus.rd_addr = A'(BASE - 3 + $urandom_range(0, 8));
            reset_n     = ($urandom_range(0, 99) != 0);
        end
        @(negedge clock);
        idle();
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           sent;
        int           got;
        int           edges;
        logic         acc;
        logic [W-1:0] seen [$];
        logic [63:0]  seen_v;

        idle();
        bus.in_data  = '0;
        bus.in_valid = '1;
        repeat (3) @(posedge clock);
        #2;
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_port_EF", port_EF, 0);
        check("reset_rd_data", bus.rd_data, 0);
        check("reset_rd_valid", bus.rd_data_valid, 0);
        check("reset_underrun", underrun_count, 0);

        @(negedge clock);
        reset_n = 1'b1;
        idle();
        #1 check("ready_after_reset", bus.in_ready, 4'hF);

        // fill and drain port 2
        @(negedge clock);
        bus.in_valid = 4'b0100;
        bus.in_data[2*W +: W] = 36'h123456789;
        @(posedge clock); #2;
        check("fill_port_EF", port_EF, 4'b0100);
        @(negedge clock);
        bus.in_valid = '0;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 10'h3F2;
        @(posedge clock); #2;
        check("drain_rd_data", bus.rd_data, 36'h123456789);
        check("drain_rd_valid", bus.rd_data_valid, 1);
        check("drain_port_EF", port_EF, 0);

        // three underruns on empty port 1
        @(negedge clock);
        bus.rd_addr = 10'h3F1;
        repeat (3) begin
            @(posedge clock); #2;
            check("underrun_rd_valid", bus.rd_data_valid, 0);
        end
        check("underrun_count_3", underrun_count, 3);

        // out-of-range read with every port full
        @(negedge clock);
        idle();
        bus.in_valid = 4'hF;
        bus.in_data  = {36'hA3, 36'hA2, 36'hA1, 36'hA0};
        @(negedge clock);
        idle();
        bus.rd_en   = 1'b1;
        bus.rd_addr = 10'h3EF;
        @(posedge clock); #2;
        check("oor_port_EF", port_EF, 4'hF);
        check("oor_rd_valid", bus.rd_data_valid, 0);
        check("oor_rd_data_held", bus.rd_data, 36'h123456789);
        check("oor_underrun", underrun_count, 3);

        // saturation
        do_reset();
        bus.rd_en   = 1'b1;
        bus.rd_addr = 10'h3F1;
        repeat (300) @(posedge clock);
        #2 check("underrun_saturated", underrun_count, 255);

        // asynchronous reset with port 3 full
        do_reset();
        bus.in_valid = 4'b1000;
        bus.in_data[3*W +: W] = 36'hABCDEF012;
        @(negedge clock);
        idle();
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1 check("async_reset_port_EF", port_EF, 0);
        @(negedge clock);
        reset_n     = 1'b1;
        bus.rd_en   = 1'b1;
        bus.rd_addr = 10'h3F3;
        @(posedge clock); #2;
        check("async_reset_rd_valid", bus.rd_data_valid, 0);
        check("async_reset_rd_data", bus.rd_data, 0);
        check("async_reset_underrun", underrun_count, 1);

        // throughput on port 0 with continuous reads
        do_reset();
        sent  = 0;
        got   = 0;
        edges = 0;
        while (got < 4 && edges < 20) begin
            @(negedge clock);
            bus.rd_en       = 1'b1;
            bus.rd_addr     = A'(BASE);
            bus.in_valid[0] = (sent < 4);
            bus.in_data[W-1:0] = W'(sent + 1);
            #1 acc = bus.in_valid[0] && bus.in_ready[0];
            @(posedge clock);
            edges++;
            if (acc) sent++;
            #2;
            if (bus.rd_data_valid === 1'b1) begin
                seen.push_back(bus.rd_data);
                got++;
            end
        end
`ifdef IO_READ_BYPASS_EN
        check("throughput_cycles", edges, 5);
`else
        check("throughput_cycles", edges, 8);
`endif
        check("throughput_words", got, 4);
        for (int i = 0; i < 4; i++) begin
            seen_v = (i < seen.size()) ? 64'(seen[i]) : 64'hDEAD;
            check("throughput_order", seen_v, i + 1);
        end
        @(negedge clock);
        idle();

        // random traffic
        do_reset();
        random_phase(600);
        repeat (3) @(posedge clock);
        #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/io_read_port_ctrl.md
# io_read_port_ctrl

Owns the `PORT_COUNT` memory-mapped read ports and produces the per-port Empty/Full bits that the I/O check logic consumes. Each port holds one word pushed by an external producer over a valid/ready handshake. A committed processor read of a FULL port returns the word and frees the slot. Sits between external producers and the A/B read path, one instance per readable operand space.

## Interface
Parameters:
- `WORD_WIDTH`, 36, port data width.
- `ADDR_WIDTH`, 10, processor read address width.
- `PORT_COUNT`, 4, number of read ports (≥1).
- `PORT_BASE_ADDR`, 0, address of port 0; ports occupy `[BASE, BASE+PORT_COUNT)`.
- `PORT_ADDR_WIDTH`, 2, low address bits selecting the port (`2^PORT_ADDR_WIDTH ≥ PORT_COUNT`).

Ports:
- `clock`, in, 1: single clock; all state on rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_data`, in, `PORT_COUNT*WORD_WIDTH`: producer words; port p at bits `[p*WORD_WIDTH +: WORD_WIDTH]`.
- `in_valid`, in, `PORT_COUNT`: producer offers a word.
- `in_ready`, out, `PORT_COUNT`: port accepts a word this cycle.
- `rd_addr`, in, `ADDR_WIDTH`: committed read address.
- `rd_en`, in, 1: read commits this cycle (instruction not annulled).
- `port_EF`, out, `PORT_COUNT`: 1 = FULL (`FULL`), 0 = EMPTY (`EMPTY`).
- `rd_data`, out, `WORD_WIDTH`: registered read data.
- `rd_data_valid`, out, 1: `rd_data` updated by a successful read.
- `underrun_count`, out, 8: saturating count of reads committed to EMPTY ports.

## Operation
- Per-port FSM, two states: EMPTY and FULL; `port_EF[p]` = (state == FULL), driven directly from the state flop.
- EMPTY → FULL: `in_valid[p] && in_ready[p]`; word captured into holding register p.
- FULL → EMPTY: read hit on p while FULL.
- Read hit on p: `rd_en`, `rd_addr` within `[PORT_BASE_ADDR, PORT_BASE_ADDR+PORT_COUNT)`, and `p = rd_addr - PORT_BASE_ADDR`.
- `in_ready[p]` = (state EMPTY) and `reset_n` high.
- Successful read: `rd_data` ← holding register p, `rd_data_valid` ← 1.
- Any other cycle: `rd_data` holds its value; `rd_data_valid` ← 0.
- Read hit on an EMPTY port:
  - no state change;
  - `rd_data_valid` ← 0;
  - `underrun_count` increments, saturating at 255.
- `rd_en` with an address outside the port range: ignored entirely (memory access, not I/O).
- Ports are independent; a read of p and a write into q≠p in the same cycle both take effect.

## Timing
- Reset (`reset_n` low, asynchronous):
  - all ports EMPTY; `port_EF` = 0;
  - `in_ready` = 0;
  - `rd_data` = 0, `rd_data_valid` = 0, `underrun_count` = 0.
- Reset applied mid-handshake or mid-read discards the held word; nothing is retained.
- After `reset_n` rises: `in_ready` = 1 in the same cycle; first capture occurs at the next edge.
- Write latency: handshake at edge N → `port_EF[p]` = 1 after edge N; readable from cycle N+1.
- Read latency: hit at edge N → `rd_data` and `rd_data_valid` valid after edge N; `port_EF[p]` = 0 and `in_ready[p]` = 1 after edge N.
- Refill without bypass: earliest at edge N+1, i.e. one word per 2 cycles per port.
- Read of a FULL port while `in_valid[p]` is high (no bypass): read wins; the producer waits one cycle.

## Configuration
- `IO_READ_BYPASS_EN` defined:
  - `in_ready[p]` also asserts while FULL when the same cycle carries a read hit on p;
  - the outgoing word goes to `rd_data` and the incoming word is captured; state stays FULL;
  - sustains one word per cycle per port;
  - `in_ready` then combinationally depends on `rd_en`/`rd_addr`.
- `IO_READ_BYPASS_EN` undefined: `in_ready[p]` depends only on state; behaviour as above.

## Test plan
- Reset: hold `reset_n` low with `in_valid` = 4'b1111 → `in_ready` = 0, `port_EF` = 0, `rd_data` = 0, `underrun_count` = 0.
- Fill and drain port 2 (BASE = 0x3F0):
  - push 36'h123456789 → `port_EF` = 4'b0100 next cycle;
  - read 0x3F2 → `rd_data` = 36'h123456789 and `rd_data_valid` = 1 next cycle, `port_EF` = 0.
- Underrun: read 0x3F1 (EMPTY) three times → `rd_data_valid` stays 0, `underrun_count` = 3.
  - Also force 300 underruns → count stays at 255.
- Out-of-range read 0x3EF with all ports FULL → no state change, `rd_data_valid` = 0.
- Throughput on port 0, producer streaming 1, 2, 3, 4 with continuous reads:
  - without `IO_READ_BYPASS_EN`: 4 words in 8 cycles;
  - with `IO_READ_BYPASS_EN`: 4 words in 5 cycles.
  - Both: `rd_data` order is 1, 2, 3, 4.
- Async reset asserted mid-cycle with port 3 FULL → `port_EF` = 0 immediately; the held word never appears on `rd_data`.
